// File: rtl/mux_nx1_arb_if.sv
// Bundle of the producer-side and consumer-side handshake signals of mux_nx1_arb.
// The slave modport is the mux itself; the master modport is whoever drives it.
interface mux_nx1_arb_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_grant;
  logic           out_ready;

  modport master (
    output in_valid, in_data, mode, sel, out_ready,
    input  in_ready, out_valid, out_data, out_grant
  );

  modport slave (
    input  in_valid, in_data, mode, sel, out_ready,
    output in_ready, out_valid, out_data, out_grant
  );
endinterface

// File: rtl/mux_nx1_arb.sv
// N-to-1 registered multiplexer with per-channel valid/ready.
// Source is either a fixed index (mode=0, sel) or a round-robin arbiter (mode=1).
// A single output register decouples the chosen producer from the consumer.
module mux_nx1_arb #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  mux_nx1_arb_if.slave  bus
);
  localparam int SW = $clog2(N);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  data_q;
  logic [SW-1:0] grant_q;
  logic [SW-1:0] ptr;

  logic          load_en;
  logic          gnt_vld;
  logic [SW-1:0] gnt;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  hi_req;
  logic          hi_vld;
  logic [SW-1:0] hi_idx;
  logic          lo_vld;
  logic [SW-1:0] lo_idx;
  logic          accept;
  logic [SW-1:0] ptr_next;
  logic [W-1:0]  mux_data;
  logic [N-1:0]  ready;

  assign load_en = (state == S_EMPTY) || bus.out_ready;

  // Rotating priority without modulo arithmetic: the lowest requester at or
  // above ptr wins; if there is none, the search wraps to the lowest requester overall.
  assign hi_mask = {N{1'b1}} << ptr;
  assign hi_req  = bus.in_valid & hi_mask;

  // Grant selection for both select mode and round-robin mode.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    hi_vld  = 1'b0;
    hi_idx  = '0;
    lo_vld  = 1'b0;
    lo_idx  = '0;
    if (!bus.mode) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (bus.sel == SW'(k) && bus.in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt     = SW'(k);
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (hi_req[k] && !hi_vld) begin
          hi_vld = 1'b1;
          hi_idx = SW'(k);
        end
        if (bus.in_valid[k] && !lo_vld) begin
          lo_vld = 1'b1;
          lo_idx = SW'(k);
        end
      end
      gnt_vld = lo_vld;
      gnt     = hi_vld ? hi_idx : lo_idx;
    end
  end

  assign accept   = !rst && load_en && gnt_vld;
  assign ptr_next = (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);

  // Data steering and the one-hot ready decode for the granted channel.
  always_comb begin
    mux_data = '0;
    ready    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt == SW'(k)) begin
        mux_data = bus.in_data[k*W +: W];
        ready[k] = accept;
      end
    end
  end

  // Output register, fill state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_EMPTY;
      data_q  <= '0;
      grant_q <= '0;
      ptr     <= '0;
    end else begin
      if (accept) begin
        state   <= S_FULL;
        data_q  <= mux_data;
        grant_q <= gnt;
        if (bus.mode) begin
          ptr <= ptr_next;
        end
      end else if (bus.out_ready) begin
        state <= S_EMPTY;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == S_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_grant = grant_q;
endmodule

// File: tb/tb_mux_nx1_arb.sv
// Bench for mux_nx1_arb: three builds (N=4, N=5, N=3) share one stimulus stream.
// A table of directed vectors targets the N=4 build, short sequences cover the
// N=5 out-of-range select and N=3 wrap-around, and a random phase is compared
// cycle by cycle against a behavioural model of all three builds.
module tb_mux_nx1_arb;
  logic        clk;
  logic        rst;
  logic [4:0]  s_valid;
  logic [39:0] s_data;
  logic        s_mode;
  logic [2:0]  s_sel;
  logic        s_ordy;

  int checks   = 0;
  int failures = 0;

  mux_nx1_arb_if #(.N(4), .W(8)) bus4 ();
  mux_nx1_arb_if #(.N(5), .W(8)) bus5 ();
  mux_nx1_arb_if #(.N(3), .W(8)) bus3 ();

  assign bus4.in_valid  = s_valid[3:0];
  assign bus4.in_data   = s_data[31:0];
  assign bus4.mode      = s_mode;
  assign bus4.sel       = s_sel[1:0];
  assign bus4.out_ready = s_ordy;

  assign bus5.in_valid  = s_valid;
  assign bus5.in_data   = s_data;
  assign bus5.mode      = s_mode;
  assign bus5.sel       = s_sel;
  assign bus5.out_ready = s_ordy;

  assign bus3.in_valid  = s_valid[2:0];
  assign bus3.in_data   = s_data[23:0];
  assign bus3.mode      = s_mode;
  assign bus3.sel       = s_sel[1:0];
  assign bus3.out_ready = s_ordy;

  mux_nx1_arb #(.N(4), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_nx1_arb #(.N(5), .W(8)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  mux_nx1_arb #(.N(3), .W(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int mn[3]  = '{4, 5, 3};
  int msk[3] = '{3, 7, 3};
  int m_ptr[3];
  bit m_ov[3];
  int m_od[3];
  int m_og[3];
  bit m_sync = 0;

  // Channel the rules pick this cycle, or -1 if none.
  function automatic int model_grant(int d);
    int n;
    int sl;
    int c;
    n  = mn[d];
    sl = int'(s_sel) & msk[d];
    if (!s_mode) begin
      if (sl < n && s_valid[sl]) return sl;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      c = (m_ptr[d] + k) % n;
      if (s_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int model_ready(int d);
    int g;
    if (rst) return 0;
    g = model_grant(d);
    if ((!m_ov[d] || s_ordy) && g >= 0) return 1 << g;
    return 0;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_sync <= 1'b1;
      for (int d = 0; d < 3; d++) begin
        m_ptr[d] <= 0;
        m_ov[d]  <= 1'b0;
        m_od[d]  <= 0;
        m_og[d]  <= 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        g = model_grant(d);
        if ((!m_ov[d] || s_ordy) && g >= 0) begin
          m_ov[d] <= 1'b1;
          m_od[d] <= int'((s_data >> (8 * g)) & 40'hFF);
          m_og[d] <= g;
          if (s_mode) m_ptr[d] <= (g + 1) % mn[d];
        end else if (s_ordy) begin
          m_ov[d] <= 1'b0;
        end
      end
    end
  end

  task automatic check_dut(int d, logic [4:0] r, logic ov, logic [7:0] od, logic [2:0] og);
    string tag;
    tag = $sformatf("model_n%0d", mn[d]);
    check({tag, "_in_ready"},  64'(r),  64'(model_ready(d)));
    check({tag, "_out_valid"}, 64'(ov), 64'(m_ov[d]));
    check({tag, "_out_data"},  64'(od), 64'(m_od[d]));
    check({tag, "_out_grant"}, 64'(og), 64'(m_og[d]));
  endtask

  always @(negedge clk) begin
    if (m_sync) begin
      check_dut(0, 5'(bus4.in_ready), bus4.out_valid, bus4.out_data, 3'(bus4.out_grant));
      check_dut(1, bus5.in_ready,     bus5.out_valid, bus5.out_data, bus5.out_grant);
      check_dut(2, 5'(bus3.in_ready), bus3.out_valid, bus3.out_data, 3'(bus3.out_grant));
    end
  end

  // ---------------- directed vectors (N=4 build) ----------------
  typedef struct {
    bit         r;
    bit         md;
    logic [2:0] sl;
    logic [3:0] v;
    bit         ordy;
    logic [3:0] er;
    bit         eov;
    logic [7:0] eod;
    logic [1:0] eog;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit md, int sl, int v, bit ordy,
                              int er, bit eov, int eod, int eog);
    vec_t t;
    t.r = r; t.md = md; t.sl = 3'(sl); t.v = 4'(v); t.ordy = ordy;
    t.er = 4'(er); t.eov = eov; t.eod = 8'(eod); t.eog = 2'(eog);
    return t;
  endfunction

  task automatic drive(bit r, bit md, logic [2:0] sl, logic [4:0] v, bit ordy);
    rst = r; s_mode = md; s_sel = sl; s_valid = v; s_ordy = ordy;
  endtask

  initial begin
    drive(1'b1, 1'b1, 3'd0, 5'h1F, 1'b1);
    s_data = 40'h55_4433_2211;

    //              rst md sel v     ordy | ready ov data  grant
    tbl.push_back(mk(1, 1, 0, 4'hF, 1,  4'h0, 0, 8'h00, 0)); // reset, all valid
    tbl.push_back(mk(1, 1, 0, 4'hF, 1,  4'h0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h1, 1, 8'h11, 0)); // round robin 0..3 twice
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h2, 1, 8'h22, 1));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h4, 1, 8'h33, 2));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h8, 1, 8'h44, 3));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h1, 1, 8'h11, 0));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h2, 1, 8'h22, 1));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h4, 1, 8'h33, 2));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h8, 1, 8'h44, 3));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h1, 1, 8'h11, 0));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h2, 1, 8'h22, 1)); // FULL with 0x22
    tbl.push_back(mk(0, 1, 0, 4'hF, 0,  4'h0, 1, 8'h22, 1)); // backpressure x3
    tbl.push_back(mk(0, 1, 0, 4'hF, 0,  4'h0, 1, 8'h22, 1));
    tbl.push_back(mk(0, 1, 0, 4'hF, 0,  4'h0, 1, 8'h22, 1));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h4, 1, 8'h33, 2)); // take + reload
    tbl.push_back(mk(0, 0, 2, 4'hF, 1,  4'h4, 1, 8'h33, 2)); // select sel=2
    tbl.push_back(mk(0, 0, 2, 4'hF, 1,  4'h4, 1, 8'h33, 2));
    tbl.push_back(mk(0, 1, 0, 4'h2, 1,  4'h2, 1, 8'h22, 1)); // leaves ptr=2
    tbl.push_back(mk(0, 0, 0, 4'hF, 1,  4'h1, 1, 8'h11, 0)); // select sel=0 x2
    tbl.push_back(mk(0, 0, 0, 4'hF, 1,  4'h1, 1, 8'h11, 0));
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h4, 1, 8'h33, 2)); // resumes at ptr=2
    tbl.push_back(mk(0, 1, 0, 4'h5, 1,  4'h1, 1, 8'h11, 0)); // sparse, ptr=3 -> 0
    tbl.push_back(mk(0, 1, 0, 4'h5, 1,  4'h4, 1, 8'h33, 2)); // ptr=1 -> 2
    tbl.push_back(mk(0, 1, 0, 4'h5, 1,  4'h1, 1, 8'h11, 0)); // ptr=3 -> 0
    tbl.push_back(mk(0, 0, 3, 4'h7, 1,  4'h0, 0, 8'h11, 0)); // selected channel idle: drains
    tbl.push_back(mk(0, 1, 0, 4'hF, 0,  4'h2, 1, 8'h22, 1)); // EMPTY loads despite !out_ready
    tbl.push_back(mk(1, 1, 0, 4'hF, 1,  4'h0, 0, 8'h00, 0)); // reset mid-transfer
    tbl.push_back(mk(0, 1, 0, 4'hF, 1,  4'h1, 1, 8'h11, 0)); // ptr back at 0

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].md, tbl[i].sl, {1'b0, tbl[i].v}, tbl[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 64'(bus4.in_ready), 64'(tbl[i].er));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), 64'(bus4.out_valid), 64'(tbl[i].eov));
      check($sformatf("vec%0d_out_data", i),  64'(bus4.out_data),  64'(tbl[i].eod));
      check($sformatf("vec%0d_out_grant", i), 64'(bus4.out_grant), 64'(tbl[i].eog));
    end

    // N=5: sel=5 is out of range, so no grant and the held word drains.
    drive(1'b1, 1'b0, 3'd2, 5'h1F, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd2, 5'h1F, 1'b1);
    @(posedge clk); #1;
    check("n5_sel2_valid", 64'(bus5.out_valid), 64'd1);
    check("n5_sel2_data",  64'(bus5.out_data),  64'h33);
    check("n5_sel2_grant", 64'(bus5.out_grant), 64'd2);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 3'd5, 5'h1F, 1'b1);
      @(negedge clk);
      check($sformatf("n5_sel5_ready%0d", c), 64'(bus5.in_ready), 64'd0);
      @(posedge clk); #1;
      check($sformatf("n5_sel5_valid%0d", c), 64'(bus5.out_valid), 64'd0);
    end

    // N=3: grant after channel 2 wraps to channel 0.
    drive(1'b1, 1'b1, 3'd0, 5'h1F, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      int eg;
      eg = c % 3;
      drive(1'b0, 1'b1, 3'd0, 5'h1F, 1'b1);
      @(posedge clk); #1;
      check($sformatf("n3_wrap_grant%0d", c), 64'(bus3.out_grant), 64'(eg));
      check($sformatf("n3_wrap_data%0d", c),  64'(bus3.out_data),  64'((eg + 1) * 8'h11));
    end

    // Random phase, checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 64) == 0, ($urandom % 4) != 0, 3'($urandom),
            5'($urandom), ($urandom % 4) != 0);
      s_data = {8'($urandom), 32'($urandom)};
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
